audio_channel_link: RTL and testbench

Stage between the BCH encoders and the BCH decoders in the audio transmit/receive path, with one instance shared by both channels. It runs the read/write handshake with `audio_codec` and captures the encoded left/right words. The words are buffered in a small stereo FIFO and replayed toward the decoders. An optional single-bit error injector exercises the BCH correction path on hardware.

---
 rtl/audio_channel_link.sv | 144 ++++++++++++++
 tb/tb_audio_channel_link.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_channel_link.sv
// Stereo link between the BCH encoders and decoders: runs the codec read/write
// strobes, buffers encoded left/right pairs in a small FIFO and replays them,
// optionally flipping one bit of the left word every ERR_PERIOD pushes.
module audio_channel_link #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ERR_PERIOD = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read_ready,
  input  logic                     write_ready,
  input  logic [WIDTH-1:0]         tx_left,
  input  logic [WIDTH-1:0]         tx_right,
  input  logic                     err_en,
  output logic                     read,
  output logic                     write,
  output logic [WIDTH-1:0]         rx_left,
  output logic [WIDTH-1:0]         rx_right,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              err_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(ERR_PERIOD - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;

  typedef enum logic {IDLE, STROBE} strobe_e;

  strobe_e rd_state_q, rd_state_d;
  strobe_e wr_state_q, wr_state_d;

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [WIDTH-1:0]   rx_left_q, rx_left_d;
  logic [WIDTH-1:0]   rx_right_q, rx_right_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        errcnt_q, errcnt_d;

  logic               full, empty, push, pop, inject, lfsr_fb;
  logic [31:0]        pos_raw, bitpos;
  logic [WIDTH-1:0]   err_mask, left_in;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = (rd_state_q == STROBE);
  assign pop   = (wr_state_q == IDLE) && !empty && write_ready;

  assign read       = (rd_state_q == STROBE);
  assign write      = (wr_state_q == STROBE);
  assign rx_left    = rx_left_q;
  assign rx_right   = rx_right_q;
  assign fifo_level = level_q;
  assign err_count  = errcnt_q;

  // Read and write strobe machines: one-cycle STROBE, never back to back.
  always_comb begin
    rd_state_d = IDLE;
    wr_state_d = IDLE;
    case (rd_state_q)
      IDLE:    if (read_ready && !full) rd_state_d = STROBE;
      STROBE:  rd_state_d = IDLE;
      default: rd_state_d = IDLE;
    endcase
    case (wr_state_q)
      IDLE:    if (write_ready && !empty) wr_state_d = STROBE;
      STROBE:  wr_state_d = IDLE;
      default: wr_state_d = IDLE;
    endcase
  end

  // Error injection: bit position from the pre-advance LFSR, folded into the word.
  // LFSR is the right-shift form of taps 16,14,13,11 (feedback from bits 0,2,3,5).
  always_comb begin
    pos_raw  = 32'(lfsr_q[4:0]);
    bitpos   = (pos_raw >= WIDTH) ? (pos_raw - WIDTH) : pos_raw;
    inject   = err_en && (cnt_q == CNT_LAST);
    err_mask = inject ? (ONE << bitpos) : '0;
    left_in  = tx_left ^ err_mask;
    lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    errcnt_d = errcnt_q;
    if (push) begin
      lfsr_d = {lfsr_fb, lfsr_q[15:1]};
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      if (inject && (errcnt_q != 16'hFFFF)) errcnt_d = errcnt_q + 16'd1;
    end
  end

  // FIFO pointers, occupancy and output holding registers.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    rx_left_d  = rx_left_q;
    rx_right_d = rx_right_q;
    if (pop) {rx_left_d, rx_right_d} = mem_q[rd_ptr_q];
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control and datapath state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_state_q <= IDLE;
      wr_state_q <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rx_left_q  <= '0;
      rx_right_q <= '0;
      lfsr_q     <= LFSR_SEED;
      cnt_q      <= '0;
      errcnt_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rx_left_q  <= rx_left_d;
      rx_right_q <= rx_right_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      errcnt_q   <= errcnt_d;
    end
  end

  // Pair storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= {left_in, tx_right};
  end

endmodule

// File: tb/tb_audio_channel_link.sv
// Directed bench for audio_channel_link (WIDTH=24, DEPTH=8, ERR_PERIOD=4).
module tb_audio_channel_link;

  logic        clk;
  logic        reset;
  logic        read_ready, write_ready, err_en;
  logic [23:0] tx_left, tx_right;
  logic        read, write;
  logic [23:0] rx_left, rx_right;
  logic [3:0]  fifo_level;
  logic [15:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  logic [47:0] outq[$];
  int read_cnt = 0;
  logic prev_read = 0, prev_write = 0;
  logic mon_stream = 0;
  int max_lvl = 0;
  logic saw0 = 0, saw1 = 0;

  int npush = 0;
  int push_limit = 1000;
  int mode = 0;

  audio_channel_link #(.WIDTH(24), .DEPTH(8), .ERR_PERIOD(4)) dut (
    .clk(clk), .reset(reset), .read_ready(read_ready), .write_ready(write_ready),
    .tx_left(tx_left), .tx_right(tx_right), .err_en(err_en),
    .read(read), .write(write), .rx_left(rx_left), .rx_right(rx_right),
    .fifo_level(fifo_level), .err_count(err_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output logger plus strobe-spacing checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (write === 1'b1) outq.push_back({rx_left, rx_right});
      if (read === 1'b1) read_cnt++;
      if (mon_stream) begin
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        if (fifo_level == 4'd0) saw0 = 1;
        if (fifo_level == 4'd1) saw1 = 1;
      end
      if (prev_read === 1'b1) check("read_gap", read, 0);
      if (prev_write === 1'b1) check("write_gap", write, 0);
    end
    prev_read  = read;
    prev_write = write;
  end

  task automatic set_pattern();
    case (mode)
      1: begin
        tx_left  = 24'(npush + 1);
        tx_right = 24'hF00000 | 24'(npush + 1);
      end
      2: begin
        tx_left  = 24'h000100 + 24'(npush);
        tx_right = ~(24'h000100 + 24'(npush));
      end
      default: ;
    endcase
  endtask

  // One clock: note whether this edge pushes, then advance the source pattern.
  task automatic cycle();
    logic rw, rs;
    rw = read;
    rs = reset;
    @(posedge clk);
    #1;
    if (rw === 1'b1 && rs === 1'b1) begin
      npush++;
      set_pattern();
      if (npush >= push_limit) read_ready = 0;
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic b;
    b = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {b, l[15:1]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lf;
    int pos;
    logic [23:0] expl;

    reset = 0; read_ready = 1; write_ready = 1; err_en = 0;
    tx_left = 0; tx_right = 0;

    // Reset held with both ready lines high
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_read", read, 0);
      check("rst_write", write, 0);
      check("rst_rx", {rx_left, rx_right}, 0);
      check("rst_level", fifo_level, 0);
      check("rst_errcnt", err_count, 0);
    end

    // Single pass-through
    reset = 1; read_ready = 0; write_ready = 1;
    tx_left = 24'h123456; tx_right = 24'hABCDEF;
    cycle();
    outq.delete(); read_cnt = 0;
    mode = 0; npush = 0; push_limit = 1; read_ready = 1;
    cycle();
    check("pt_read_on", read, 1);
    cycle();
    check("pt_read_off", read, 0);
    check("pt_level1", fifo_level, 1);
    check("pt_write_early", write, 0);
    cycle();
    check("pt_write", write, 1);
    check("pt_rx", {rx_left, rx_right}, 48'h123456ABCDEF);
    check("pt_level0", fifo_level, 0);
    repeat (4) cycle();
    check("pt_read_cnt", read_cnt, 1);
    check("pt_out_cnt", outq.size(), 1);

    // Fill and stall, then drain
    write_ready = 0; mode = 1; npush = 0; set_pattern();
    push_limit = 10; outq.delete(); read_cnt = 0; read_ready = 1;
    repeat (24) cycle();
    check("fill_reads", read_cnt, 8);
    check("fill_level", fifo_level, 8);
    check("fill_read_stall", read, 0);
    write_ready = 1;
    repeat (40) cycle();
    check("drain_reads", read_cnt, 10);
    check("drain_out_cnt", outq.size(), 10);
    for (int k = 0; k < 10 && k < outq.size(); k++)
      check("drain_data", outq[k], {24'(k + 1), 24'hF00000 | 24'(k + 1)});
    check("drain_level", fifo_level, 0);

    // Continuous stream, push and pop overlapping
    mode = 2; npush = 0; set_pattern(); push_limit = 100;
    outq.delete(); read_cnt = 0; max_lvl = 0; saw0 = 0; saw1 = 0;
    mon_stream = 1; read_ready = 1; write_ready = 1;
    for (int c = 0; c < 1000 && npush < 100; c++) cycle();
    check("stream_pushes", npush, 100);
    repeat (10) cycle();
    mon_stream = 0;
    check("stream_max_level", max_lvl, 1);
    check("stream_saw_level1", saw1, 1);
    check("stream_saw_level0", saw0, 1);
    check("stream_out_cnt", outq.size(), 100);
    for (int k = 0; k < 100 && k < outq.size(); k++)
      check("stream_data", outq[k],
            {24'h000100 + 24'(k), ~(24'h000100 + 24'(k))});

    // Error injection with ERR_PERIOD=4
    reset = 0; repeat (2) cycle();
    reset = 1; err_en = 1; mode = 0; tx_left = 0; tx_right = 24'h5A5A5A;
    outq.delete(); npush = 0; push_limit = 16; read_ready = 1; write_ready = 1;
    for (int c = 0; c < 500 && npush < 16; c++) cycle();
    repeat (10) cycle();
    err_en = 0;
    check("err_count", err_count, 4);
    check("err_out_cnt", outq.size(), 16);
    lf = 16'hACE1;
    for (int k = 1; k <= 16 && k <= outq.size(); k++) begin
      pos = int'(lf[4:0]);
      if (pos >= 24) pos = pos - 24;
      expl = 24'h1;
      expl = (k % 4 == 0) ? (expl << pos) : 24'h0;
      check("err_data", outq[k-1], {expl, 24'h5A5A5A});
      lf = lfsr_next(lf);
    end

    // Reset mid-stream with level 5 and write active
    reset = 0; cycle(); cycle();
    reset = 1; mode = 1; npush = 0; set_pattern(); push_limit = 6;
    write_ready = 0; read_ready = 1;
    for (int c = 0; c < 40 && npush < 6; c++) cycle();
    cycle();
    check("mid_fill_level", fifo_level, 6);
    write_ready = 1;
    cycle();
    check("mid_write", write, 1);
    check("mid_level5", fifo_level, 5);
    reset = 0;
    cycle();
    check("mid_rst_write", write, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_read", read, 0);
    check("mid_rst_rx", {rx_left, rx_right}, 0);
    reset = 1; outq.delete();
    mode = 0; tx_left = 24'h777777; tx_right = 24'h888888;
    npush = 0; push_limit = 1; read_ready = 1;
    repeat (8) cycle();
    check("post_rst_out_cnt", outq.size(), 1);
    if (outq.size() > 0) check("post_rst_data", outq[0], 48'h777777888888);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
